// File: rtl/muxn_arb_pkg.sv
// Shared definitions for the M-input registered multiplexer/arbiter.
package muxn_arb_pkg;

  // Grant-selection policy of a muxn_arb instance.
  typedef enum logic [1:0] {
    MUX_MODE_SEL  = 2'd0,  // explicit channel select
    MUX_MODE_PRIO = 2'd1,  // fixed priority, channel 0 highest
    MUX_MODE_RR   = 2'd2   // round-robin
  } mux_mode_e;

endpackage

// File: rtl/muxn_arb_if.sv
// Producer/consumer bus of muxn_arb: M input channels with valid/ready,
// explicit select, and one registered output channel with valid/ready.
interface muxn_arb_if #(
  parameter int unsigned N = 8,
  parameter int unsigned M = 4
);
  localparam int unsigned SW = $clog2(M);

  logic [M*N-1:0] in_data;
  logic [M-1:0]   in_valid;
  logic [M-1:0]   in_ready;
  logic [SW-1:0]  sel;
  logic [N-1:0]   out_data;
  logic [SW-1:0]  out_chan;
  logic           out_valid;
  logic           out_ready;

  // Environment side: drives producers and consumer ready.
  modport master (
    output in_data, in_valid, sel, out_ready,
    input  in_ready, out_data, out_chan, out_valid
  );

  // Multiplexer side.
  modport slave (
    input  in_data, in_valid, sel, out_ready,
    output in_ready, out_data, out_chan, out_valid
  );
endinterface

// File: rtl/muxn_arb_arb_rr.sv
// Rotating-priority arbiter: first requester found searching from ptr
// upward modulo M. With ptr tied to zero it is a fixed-priority arbiter.
module arb_rr #(
  parameter int unsigned M  = 4,
  parameter int unsigned SW = $clog2(M)
) (
  input  logic [M-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic [M-1:0]  gnt,
  output logic [SW-1:0] gnt_idx
);

  logic        found;
  int unsigned idx;

  // Scan M positions starting at ptr; the first active request wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int unsigned k = 0; k < M; k++) begin
      idx = (32'(ptr) + k) % M;
      if (!found && req[idx]) begin
        found      = 1'b1;
        gnt[idx]   = 1'b1;
        gnt_idx    = SW'(idx);
      end
    end
  end

endmodule

// File: rtl/muxn_arb.sv
// M-input, N-bit registered multiplexer with per-channel valid/ready.
// Grant policy chosen at elaboration: explicit select, fixed priority or
// round-robin. One-entry output register, one word per cycle throughput.
module muxn_arb
  import muxn_arb_pkg::*;
#(
  parameter int unsigned N    = 8,
  parameter int unsigned M    = 4,
  parameter mux_mode_e   MODE = MUX_MODE_SEL
) (
  input  logic        clk,
  input  logic        rst_n,
  muxn_arb_if.slave   bus
);

  localparam int unsigned SW = $clog2(M);

  logic [M-1:0]  grant;
  logic [SW-1:0] g_idx;
  logic [M-1:0]  in_ready;
  logic          load;
  logic          xfer;

  logic          out_valid_q, out_valid_d;
  logic [N-1:0]  out_data_q,  out_data_d;
  logic [SW-1:0] out_chan_q,  out_chan_d;

  generate
    if (MODE == MUX_MODE_SEL) begin : g_sel
      // Explicit select; an out-of-range sel grants nothing.
      always_comb begin
        grant = '0;
        g_idx = bus.sel;
        if (32'(bus.sel) < M) begin
          grant[bus.sel] = bus.in_valid[bus.sel];
        end
      end
    end else if (MODE == MUX_MODE_PRIO) begin : g_prio
      arb_rr #(.M(M), .SW(SW)) u_arb (
        .req     (bus.in_valid),
        .ptr     ('0),
        .gnt     (grant),
        .gnt_idx (g_idx)
      );
    end else begin : g_rr
      logic [SW-1:0] rr_ptr_q, rr_ptr_d;

      arb_rr #(.M(M), .SW(SW)) u_arb (
        .req     (bus.in_valid),
        .ptr     (rr_ptr_q),
        .gnt     (grant),
        .gnt_idx (g_idx)
      );

      // Pointer moves just past the channel that transferred.
      always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (xfer) begin
          rr_ptr_d = (32'(g_idx) == M - 1) ? '0 : g_idx + 1'b1;
        end
      end

      // Round-robin pointer register.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rr_ptr_q <= '0;
        else        rr_ptr_q <= rr_ptr_d;
      end
    end
  endgenerate

  // Accept when the register is empty or draining; never during reset.
  always_comb begin
    load     = !out_valid_q || bus.out_ready;
    in_ready = rst_n ? (grant & {M{load}}) : '0;
    xfer     = |(bus.in_valid & in_ready);
  end

  // Output register next state: load beats drain, drain keeps data/chan.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = bus.in_data[g_idx*N +: N];
      out_chan_d  = g_idx;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_chan  = out_chan_q;

endmodule

// File: tb/tb_muxn_arb.sv
// Directed bench: one muxn_arb per grant mode (N=8, M=4), shared clock/reset.
module tb_muxn_arb;
  import muxn_arb_pkg::*;

  localparam int unsigned N = 8;
  localparam int unsigned M = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  muxn_arb_if #(.N(N), .M(M)) if0 ();
  muxn_arb_if #(.N(N), .M(M)) if1 ();
  muxn_arb_if #(.N(N), .M(M)) if2 ();

  muxn_arb #(.N(N), .M(M), .MODE(MUX_MODE_SEL))  dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  muxn_arb #(.N(N), .M(M), .MODE(MUX_MODE_PRIO)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  muxn_arb #(.N(N), .M(M), .MODE(MUX_MODE_RR))   dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Step one clock and settle just past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int unsigned rr_exp [6] = '{0, 1, 2, 3, 0, 1};

  initial begin
    rst_n = 1'b0;
    if0.in_data = 32'hDDCCBBAA; if0.in_valid = 4'b1111; if0.sel = 2'd2; if0.out_ready = 1'b1;
    if1.in_data = 32'hDDCCBBAA; if1.in_valid = 4'b0000; if1.sel = 2'd0; if1.out_ready = 1'b1;
    if2.in_data = 32'hDDCCBBAA; if2.in_valid = 4'b1111; if2.sel = 2'd0; if2.out_ready = 1'b1;
    #2;
    // Reset state, and no ready while reset is held even with valid inputs.
    check("rst_valid", 32'(if0.out_valid), 0);
    check("rst_data",  32'(if0.out_data),  0);
    check("rst_chan",  32'(if0.out_chan),  0);
    check("rst_rdy0",  32'(if0.in_ready),  0);
    check("rst_rdy2",  32'(if2.in_ready),  0);
    tick();
    tick();
    if2.in_valid = 4'b0000;
    rst_n = 1'b1;
    #1;

    // 1: explicit select of channel 2.
    check("t1_rdy", 32'(if0.in_ready), 32'b0100);
    tick();
    check("t1_data",  32'(if0.out_data),  32'hCC);
    check("t1_chan",  32'(if0.out_chan),  2);
    check("t1_valid", 32'(if0.out_valid), 1);

    // 2: selected channel idle -> no grant, register drains.
    if0.in_valid = 4'b0001;
    #1;
    check("t2_rdy", 32'(if0.in_ready), 0);
    tick();
    check("t2_valid", 32'(if0.out_valid), 0);
    check("t2_hold",  32'(if0.out_data),  32'hCC);

    // 3: fixed priority picks lowest valid index.
    if1.in_valid = 4'b1010;
    #1;
    check("t3_rdy1", 32'(if1.in_ready), 32'b0010);
    tick();
    check("t3_data1", 32'(if1.out_data), 32'hBB);
    check("t3_chan1", 32'(if1.out_chan), 1);
    if1.in_valid = 4'b1000;
    #1;
    check("t3_rdy3", 32'(if1.in_ready), 32'b1000);
    tick();
    check("t3_data3", 32'(if1.out_data), 32'hDD);
    check("t3_chan3", 32'(if1.out_chan), 3);
    if1.in_valid = 4'b0000;

    // 4: round-robin rotation with pointer wrap.
    if2.in_valid = 4'b1111;
    #1;
    check("t4_rdy", 32'(if2.in_ready), 32'b0001);
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("t4_chan%0d", i), 32'(if2.out_chan), rr_exp[i]);
    end
    check("t4_data", 32'(if2.out_data), 32'hBB);
    if2.in_valid = 4'b0000;

    // 5: backpressure holds AA; next word lands the cycle ready returns.
    if0.sel = 2'd0; if0.in_valid = 4'b0001; if0.out_ready = 1'b0;
    tick();
    check("t5_load", 32'(if0.out_data), 32'hAA);
    if0.sel = 2'd1; if0.in_valid = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("t5_rdy%0d", i), 32'(if0.in_ready), 0);
      tick();
      check($sformatf("t5_data%0d", i), 32'(if0.out_data), 32'hAA);
      check($sformatf("t5_vld%0d", i), 32'(if0.out_valid), 1);
    end
    if0.out_ready = 1'b1;
    #1;
    check("t5_rdy_go", 32'(if0.in_ready), 32'b0010);
    tick();
    check("t5_data_go",  32'(if0.out_data),  32'hBB);
    check("t5_chan_go",  32'(if0.out_chan),  1);
    check("t5_valid_go", 32'(if0.out_valid), 1);
    if0.in_valid = 4'b0000;

    // 6: async reset while a word is held; round-robin restarts at channel 0.
    if2.in_valid = 4'b1111; if2.out_ready = 1'b0;
    tick();
    check("t6_pre_valid", 32'(if2.out_valid), 1);
    check("t6_pre_chan",  32'(if2.out_chan),  2);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_valid", 32'(if2.out_valid), 0);
    check("t6_data",  32'(if2.out_data),  0);
    check("t6_rdy",   32'(if2.in_ready),  0);
    tick();
    rst_n = 1'b1;
    if2.out_ready = 1'b1;
    #1;
    check("t6_rdy_rel", 32'(if2.in_ready), 32'b0001);
    tick();
    check("t6_chan", 32'(if2.out_chan), 0);
    check("t6_dat",  32'(if2.out_data), 32'hAA);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
